// File: rtl/seg7_reader.sv
// Reads an asynchronous active-low 7-segment pattern, debounces it and presents the hex digit with a valid/ack handshake.
// Define SEG7_READER_ERRCNT_EN to add errcnt, a saturating 8-bit count of illegal-pattern reports.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [6:0] seg,
  input  logic       ack,
  output logic [3:0] value,
  output logic       valid,
  output logic       err
`ifdef SEG7_READER_ERRCNT_EN
  ,
  output logic [7:0] errcnt
`endif
);

  typedef enum logic [1:0] {
    SAMPLE      = 2'd0,
    VALID       = 2'd1,
    WAIT_CHANGE = 2'd2
  } state_t;

  localparam logic [6:0] BLANK    = 7'h7F;
  localparam logic [3:0] STABLE_L = 4'(STABLE_CYCLES);

  // Bit 4 flags a legal digit, bits 3:0 carry the digit.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] d;
    d = 5'd0;
    case (pat)
      7'h40: d = {1'b1, 4'h0};
      7'h79: d = {1'b1, 4'h1};
      7'h24: d = {1'b1, 4'h2};
      7'h30: d = {1'b1, 4'h3};
      7'h19: d = {1'b1, 4'h4};
      7'h12: d = {1'b1, 4'h5};
      7'h02: d = {1'b1, 4'h6};
      7'h78: d = {1'b1, 4'h7};
      7'h00: d = {1'b1, 4'h8};
      7'h10: d = {1'b1, 4'h9};
      7'h08: d = {1'b1, 4'hA};
      7'h03: d = {1'b1, 4'hB};
      7'h46: d = {1'b1, 4'hC};
      7'h21: d = {1'b1, 4'hD};
      7'h06: d = {1'b1, 4'hE};
      7'h0E: d = {1'b1, 4'hF};
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  logic [6:0] seg_meta_r, seg_sync_r, seg_prev_r, pat_r, pat_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s, value_r, value_nxt_s;
  logic       valid_r, valid_nxt_s, err_r, err_nxt_s, accept_s;
  logic [4:0] decoded_s;
  state_t     state_r, state_nxt_s;

  // Synchronizer, previous-sample register and stability counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_meta_r <= BLANK;
      seg_sync_r <= BLANK;
      seg_prev_r <= BLANK;
      cnt_r      <= 4'd0;
    end else begin
      seg_meta_r <= seg;
      seg_sync_r <= seg_meta_r;
      seg_prev_r <= seg_sync_r;
      cnt_r      <= cnt_nxt_s;
    end
  end

  // Stability counter: restart on any change, saturate once stable long enough.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (seg_sync_r != seg_prev_r) begin
      cnt_nxt_s = 4'd0;
    end else if (cnt_r != STABLE_L) begin
      cnt_nxt_s = cnt_r + 4'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // A saturated counter still qualifies, so a pattern that settled during VALID is taken at once.
  assign accept_s  = (state_r == SAMPLE) && (cnt_nxt_s >= (STABLE_L - 4'd1));
  assign decoded_s = decode_seg(seg_sync_r);

  // FSM next state and next registered outputs.
  always_comb begin
    state_nxt_s = state_r;
    pat_nxt_s   = pat_r;
    value_nxt_s = value_r;
    valid_nxt_s = valid_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      SAMPLE: begin
        if (accept_s) begin
          pat_nxt_s = seg_sync_r;
          // Blank and a repeat of the last reported pattern are swallowed silently.
          if ((seg_sync_r == BLANK) || (seg_sync_r == pat_r)) begin
            state_nxt_s = WAIT_CHANGE;
          end else if (decoded_s[4]) begin
            value_nxt_s = decoded_s[3:0];
            valid_nxt_s = 1'b1;
            state_nxt_s = VALID;
          end else begin
            err_nxt_s   = 1'b1;
            state_nxt_s = WAIT_CHANGE;
          end
        end else begin
          state_nxt_s = SAMPLE;
        end
      end
      VALID: begin
        if (ack) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = WAIT_CHANGE;
        end else begin
          state_nxt_s = VALID;
        end
      end
      WAIT_CHANGE: begin
        if (seg_sync_r != pat_r) begin
          state_nxt_s = SAMPLE;
        end else begin
          state_nxt_s = WAIT_CHANGE;
        end
      end
      default: begin
        state_nxt_s = SAMPLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, latched pattern and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= SAMPLE;
      pat_r   <= BLANK;
      value_r <= 4'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pat_r   <= pat_nxt_s;
      value_r <= value_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign value = value_r;
  assign valid = valid_r;
  assign err   = err_r;

`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] errcnt_r;

  // Saturating count of err pulses, updated on the same edge as err.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      errcnt_r <= 8'd0;
    end else if (err_nxt_s && (errcnt_r != 8'hFF)) begin
      errcnt_r <= errcnt_r + 8'd1;
    end else begin
      errcnt_r <= errcnt_r;
    end
  end

  assign errcnt = errcnt_r;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Randomized and directed bench for seg7_reader against a window-based behavioural model.
module tb_seg7_reader;
  localparam int S = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic       ack = 1'b0;
  logic [3:0] value;
  logic       valid, err;
`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] errcnt;
`endif

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .clock(clock), .resetn(resetn), .seg(seg), .ack(ack),
    .value(value), .valid(valid), .err(err)
`ifdef SEG7_READER_ERRCNT_EN
    , .errcnt(errcnt)
`endif
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [6:0] legal_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: synchronizer as a 2-deep queue, stability as "last S samples identical".
  logic [6:0] m_q [$];
  logic [6:0] m_win [$];
  int         m_state;
  logic [6:0] m_pat;
  logic [3:0] e_value;
  logic       e_valid, e_err;
  int         e_errcnt;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (legal_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_q = '{7'h7F, 7'h7F};
    m_win = '{7'h7F};
    m_state = 0; m_pat = 7'h7F;
    e_value = 4'd0; e_valid = 1'b0; e_err = 1'b0; e_errcnt = 0;
  endtask

  task automatic model_edge();
    logic [6:0] ss;
    bit ready;
    int d;
    ss = m_q.pop_front();
    m_q.push_back(seg);
    m_win.push_back(ss);
    if (m_win.size() > S) void'(m_win.pop_front());
    ready = (m_win.size() == S);
    foreach (m_win[i]) if (m_win[i] != ss) ready = 1'b0;
    e_err = 1'b0;
    case (m_state)
      0: if (ready) begin
        d = lookup(ss);
        if (ss == 7'h7F || ss == m_pat) m_state = 2;
        else if (d >= 0) begin e_value = d[3:0]; e_valid = 1'b1; m_state = 1; end
        else begin e_err = 1'b1; m_state = 2; if (e_errcnt < 255) e_errcnt++; end
        m_pat = ss;
      end
      1: if (ack) begin e_valid = 1'b0; m_state = 2; end
      default: if (ss != m_pat) m_state = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0; seg = 7'h7F; ack = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if ({valid, err, value} !== 6'b0) $display("FAIL reset_state: valid/err/value got %b/%b/%h exp 0/0/0", valid, err, value);
    else pass_cnt++;
    @(negedge clock); resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total_cnt++;
      if ({valid, err, value} !== {e_valid, e_err, e_value}) $display("FAIL reset_idle cyc %0d: got %b/%b/%h exp %b/%b/%h", c, valid, err, value, e_valid, e_err, e_value);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold30();
    seg = 7'h30;
    for (int c = 1; c <= 6; c++) begin
      tick();
      total_cnt++;
      if ({valid, err, value} !== {e_valid, e_err, e_value}) $display("FAIL hold30 cyc %0d: got %b/%b/%h exp %b/%b/%h", c, valid, err, value, e_valid, e_err, e_value);
      else pass_cnt++;
    end
    total_cnt++;
    if (valid !== 1'b1 || value !== 4'h3) $display("FAIL hold30_latency: got valid=%b value=%h exp 1/3 after 6 edges", valid, value);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) tick();
    total_cnt++;
    if (valid !== 1'b1 || value !== 4'h3) $display("FAIL hold30_held: got valid=%b value=%h exp 1/3", valid, value);
    else pass_cnt++;
    ack = 1'b1; tick(); ack = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++;
      if (valid !== 1'b0 || err !== 1'b0) $display("FAIL hold30_no_rereport cyc %0d: got valid=%b err=%b exp 0/0", c, valid, err);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    int n8, n1;
    logic prev_v;
    n8 = 0; n1 = 0; prev_v = valid;
    for (int c = 0; c < 18; c++) begin
      seg = (c == 2 || c == 3) ? 7'h79 : 7'h00;
      tick();
      if (valid && !prev_v) begin
        if (value == 4'h8) n8++;
        if (value == 4'h1) n1++;
      end
      prev_v = valid;
      total_cnt++;
      if ({valid, err, value} !== {e_valid, e_err, e_value}) $display("FAIL glitch cyc %0d: got %b/%b/%h exp %b/%b/%h", c, valid, err, value, e_valid, e_err, e_value);
      else pass_cnt++;
    end
    total_cnt++;
    if (n8 != 1 || n1 != 0) $display("FAIL glitch_reports: got eight=%0d one=%0d exp 1/0", n8, n1);
    else pass_cnt++;
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_illegal();
    int pulses;
`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] start_cnt;
    start_cnt = errcnt;
`endif
    pulses = 0;
    seg = 7'h55;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (err) pulses++;
      total_cnt++;
      if (valid !== 1'b0 || err !== e_err) $display("FAIL illegal cyc %0d: got valid=%b err=%b exp 0/%b", c, valid, err, e_err);
      else pass_cnt++;
    end
    total_cnt++;
    if (pulses != 1) $display("FAIL illegal_pulses: got %0d exp 1", pulses);
    else pass_cnt++;
`ifdef SEG7_READER_ERRCNT_EN
    total_cnt++;
    if (errcnt !== start_cnt + 8'd1) $display("FAIL illegal_errcnt: got %0d exp %0d", errcnt, start_cnt + 8'd1);
    else pass_cnt++;
`endif
  endtask

  task automatic test_blank();
    seg = 7'h7F;
    for (int c = 0; c < 12; c++) begin
      tick();
      total_cnt++;
      if (valid !== 1'b0 || err !== 1'b0) $display("FAIL blank cyc %0d: got valid=%b err=%b exp 0/0", c, valid, err);
      else pass_cnt++;
    end
  endtask

  task automatic test_change_in_valid();
    seg = 7'h08;
    for (int c = 0; c < 6; c++) tick();
    total_cnt++;
    if (valid !== 1'b1 || value !== 4'hA) $display("FAIL civ_first: got valid=%b value=%h exp 1/A", valid, value);
    else pass_cnt++;
    seg = 7'h0E;
    for (int c = 0; c < 8; c++) begin
      tick();
      total_cnt++;
      if (valid !== 1'b1 || value !== 4'hA) $display("FAIL civ_hold cyc %0d: got valid=%b value=%h exp 1/A", c, valid, value);
      else pass_cnt++;
    end
    ack = 1'b1; tick(); ack = 1'b0;
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL civ_ack: got valid=%b exp 0", valid);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) tick();
    total_cnt++;
    if (valid !== 1'b1 || value !== 4'hF || {valid, value} !== {e_valid, e_value}) $display("FAIL civ_second: got valid=%b value=%h exp 1/F", valid, value);
    else pass_cnt++;
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset_mid_valid();
    seg = 7'h21;
    for (int c = 0; c < 6; c++) tick();
    total_cnt++;
    if (valid !== 1'b1 || value !== 4'hD) $display("FAIL rmv_pre: got valid=%b value=%h exp 1/D", valid, value);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if ({valid, err, value} !== 6'b0) $display("FAIL rmv_async: got %b/%b/%h exp 0/0/0", valid, err, value);
    else pass_cnt++;
    model_reset();
    @(negedge clock); resetn = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      total_cnt++;
      if (valid !== (c == 6) || {valid, err, value} !== {e_valid, e_err, e_value}) $display("FAIL rmv_after cyc %0d: got %b/%b/%h exp %b/%b/%h", c, valid, err, value, e_valid, e_err, e_value);
      else pass_cnt++;
    end
    total_cnt++;
    if (value !== 4'hD) $display("FAIL rmv_value: got %h exp D", value);
    else pass_cnt++;
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] p;
    int hold, kind;
    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 7);
      if (kind < 4) p = legal_tab[$urandom_range(0, 15)];
      else if (kind < 6) begin
        do p = 7'($urandom); while (lookup(p) >= 0 || p == 7'h7F);
      end else p = 7'h7F;
      seg = p;
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        ack = ($urandom_range(0, 3) == 0);
        tick();
        total_cnt++;
        if ({valid, err, value} !== {e_valid, e_err, e_value}) $display("FAIL random it %0d cyc %0d seg %h: got %b/%b/%h exp %b/%b/%h", it, c, p, valid, err, value, e_valid, e_err, e_value);
        else pass_cnt++;
`ifdef SEG7_READER_ERRCNT_EN
        total_cnt++;
        if (errcnt !== 8'(e_errcnt)) $display("FAIL random_errcnt it %0d: got %0d exp %0d", it, errcnt, e_errcnt);
        else pass_cnt++;
`endif
      end
    end
    ack = 1'b0;
  endtask

`ifdef SEG7_READER_ERRCNT_EN
  task automatic test_errcnt_sat();
    for (int it = 0; it < 270; it++) begin
      seg = it[0] ? 7'h55 : 7'h2A;
      for (int c = 0; c < 8; c++) tick();
    end
    total_cnt++;
    if (errcnt !== 8'd255 || e_errcnt != 255) $display("FAIL errcnt_sat: got %0d exp 255", errcnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_hold30();
    test_glitch();
    test_illegal();
    test_blank();
    test_change_in_valid();
    test_reset_mid_valid();
    test_random();
`ifdef SEG7_READER_ERRCNT_EN
    test_errcnt_sat();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
